// File: rtl/seg7_pkg.sv
// Shared constants for the scanned seven-segment decoder: glyph patterns, code widths, segment indices.
package seg7_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] SEG7_INVALID = 4'hF;

  // Segment bit positions on the bus (1 = lit)
  localparam int unsigned SEG_TOP         = 0;
  localparam int unsigned SEG_UPPER_RIGHT = 1;
  localparam int unsigned SEG_LOWER_RIGHT = 2;
  localparam int unsigned SEG_BOTTOM      = 3;
  localparam int unsigned SEG_LOWER_LEFT  = 4;
  localparam int unsigned SEG_UPPER_LEFT  = 5;
  localparam int unsigned SEG_MIDDLE      = 6;

  // Primary glyphs, written MSB = middle segment down to LSB = top segment
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b1111100;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b1100111;

  // Alternate glyphs (tailed 6, hooked 7, tailed 9)
  localparam logic [SEG_W-1:0] GLYPH_ALT_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] GLYPH_ALT_7 = 7'b0100111;
  localparam logic [SEG_W-1:0] GLYPH_ALT_9 = 7'b1101111;

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational seven-segment glyph to 4-bit digit code decoder; unknown patterns map to SEG7_INVALID.
module seg7_glyph_dec
  import seg7_pkg::*;
#(
  parameter int unsigned ALT_GLYPHS = 1
) (
  input  logic [6:0] seg_i,
  output logic [3:0] code_c_o
);

  // Primary table first, alternate glyphs layered on top when enabled
  always_comb begin
    code_c_o = SEG7_INVALID;
    case (seg_i)
      GLYPH_0: code_c_o = 4'd0;
      GLYPH_1: code_c_o = 4'd1;
      GLYPH_2: code_c_o = 4'd2;
      GLYPH_3: code_c_o = 4'd3;
      GLYPH_4: code_c_o = 4'd4;
      GLYPH_5: code_c_o = 4'd5;
      GLYPH_6: code_c_o = 4'd6;
      GLYPH_7: code_c_o = 4'd7;
      GLYPH_8: code_c_o = 4'd8;
      GLYPH_9: code_c_o = 4'd9;
      default: code_c_o = SEG7_INVALID;
    endcase
    if (ALT_GLYPHS != 0) begin
      case (seg_i)
        GLYPH_ALT_6: code_c_o = 4'd6;
        GLYPH_ALT_7: code_c_o = 4'd7;
        GLYPH_ALT_9: code_c_o = 4'd9;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed seven-segment bus, debounces each digit and publishes whole frames over valid/ready.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned ALT_GLYPHS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VAL_W = CODE_W * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CNT);

  logic [CODE_W-1:0]     code_c;
  logic                  sel_onehot_c;
  logic                  sel_bad_c;
  logic [NUM_DIGITS-1:0] sample_c;
  logic [NUM_DIGITS-1:0] lock_set_c;
  logic [VAL_W-1:0]      shadow_c;
  logic                  load_c;

  logic [VAL_W-1:0]      value_q, value_d;
  logic [NUM_DIGITS-1:0] err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sel_err_q, sel_err_d;
  logic [NUM_DIGITS-1:0] lock_q, lock_d;

  seg7_glyph_dec #(
    .ALT_GLYPHS(ALT_GLYPHS)
  ) u_glyph_dec (
    .seg_i   (seg_in),
    .code_c_o(code_c)
  );

  // Strobe qualification: only an exact one-hot strobe is a sample; other non-zero patterns are flagged
  always_comb begin
    sel_onehot_c = (digit_sel != '0) &&
                   ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);
    sel_bad_c    = (digit_sel != '0) && !sel_onehot_c;
    sample_c     = sel_onehot_c ? digit_sel : '0;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] shadow_q, shadow_d;
    logic              lock_c;

    // Debounce: count repeats of the same code, lock and capture once the count reaches saturation
    always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      lock_c   = 1'b0;
      if (sample_c[g]) begin
        if (code_c == cand_q) begin
          cnt_d = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);
        end else begin
          cand_d = code_c;
          cnt_d  = CNT_W'(1);
        end
        if (cnt_d == CNT_SAT) begin
          shadow_d = code_c;
          lock_c   = 1'b1;
        end
      end
    end

    // Per-digit debounce state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand_q   <= SEG7_INVALID;
        cnt_q    <= '0;
        shadow_q <= '0;
      end else begin
        cand_q   <= cand_d;
        cnt_q    <= cnt_d;
        shadow_q <= shadow_d;
      end
    end

    assign lock_set_c[g]              = lock_c;
    assign shadow_c[CODE_W*g +: CODE_W] = shadow_q;
  end

  // Load a frame when all digits are locked and the output register is free; a new lock beats the clear
  always_comb begin
    value_d     = value_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q | sel_bad_c;
    load_c      = (&lock_q) && (!out_valid_q || out_ready);
    lock_d      = (load_c ? '0 : lock_q) | lock_set_c;
    if (load_c) begin
      value_d     = shadow_c;
      out_valid_d = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        err_d[i] = (shadow_c[CODE_W*i +: CODE_W] == SEG7_INVALID);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Frame output, lock mask and sticky strobe error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q     <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      lock_q      <= '0;
    end else begin
      value_q     <= value_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      lock_q      <= lock_d;
    end
  end

  assign value     = value_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Multi-digit successor to the single-digit seven-segment encoder. Samples a time-multiplexed seven-segment bus with its one-hot digit strobe, decodes each glyph to a 4-bit digit code and debounces it per digit. When every digit position has locked, it publishes a whole frame through a valid/ready handshake. It sits between a scanned-display tap (or display-driver loopback) and the readout logic.

## Interface

Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions, ≥1.
- STABLE_CNT, 3: consecutive identical samples required to lock a digit, ≥1, ≤15.
- ALT_GLYPHS, 1: when 1, also accept the alternate glyphs for 6, 7 and 9.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- seg_in  in  7: segment bus; bit0 = seg 1 (top), bit1 = 2 (upper right), bit2 = 3 (lower right), bit3 = 4 (bottom), bit4 = 5 (lower left), bit5 = 6 (upper left), bit6 = 7 (middle); 1 = lit.
- digit_sel  in  NUM_DIGITS: one-hot strobe; bit i high means seg_in currently shows digit i.
- value  out  4*NUM_DIGITS: frame; digit i occupies bits [4i+3:4i]; code 4'hF = invalid glyph.
- err  out  NUM_DIGITS: bit i set when value digit i is 4'hF.
- out_valid  out  1: frame available.
- out_ready  in  1: consumer accepts the frame.
- sel_err  out  1: sticky; digit_sel was non-zero and not one-hot.

## Operation

- Glyph decode (7654321 order):
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4, 1101101→5, 1111100→6, 0000111→7, 1111111→8, 1100111→9.
  - ALT_GLYPHS=1 adds 1111101→6, 0100111→7, 1101111→9.
  - Anything else decodes to 4'hF.
- Sample cycle: digit_sel exactly one-hot. In this case:
  - A cycle with digit_sel = 0 is idle.
  - Non-zero, non-one-hot digit_sel is ignored and sets sel_err. sel_err clears only on reset.
- Per-digit state: candidate code (4b), count (sat. STABLE_CNT), locked bit, shadow code.
- On a sample for digit i with decoded code c:
  - If c == candidate: count_next = min(count+1, STABLE_CNT).
  - Otherwise: candidate := c and count_next = 1.
  - If count_next == STABLE_CNT: shadow[i] := c and locked[i] := 1.
- Invalid glyphs debounce like valid ones, so a stable blank digit publishes 4'hF.
- Frame load:
  - Condition: locked mask all-ones and output register free (out_valid == 0, or out_valid && out_ready).
  - Action: value := shadow, err recomputed, out_valid := 1, locked mask cleared.
- A locked digit relocks on its next sample while its count stays saturated, so frames re-emit at scan rate.
- Simultaneous frame-load clear and lock of digit i: set wins. The new lock counts toward the next frame; the loaded value uses the pre-edge shadow.
- Backpressure: while out_valid && !out_ready, value/err hold. Shadow keeps tracking, so the next load publishes the latest locked codes.
- out_valid drops after an accepted handshake with no load pending in the same cycle.
- Reset (any time, including mid-frame or mid-handshake):
  - value = 0, err = 0, out_valid = 0, sel_err = 0.
  - All counts 0, candidates 4'hF, locked 0, shadow 0.

## Timing

- Decode is combinational. Candidate, count, lock and shadow update on the sample edge.
- Lock of the last digit at edge N → out_valid high after edge N+1 (1-cycle load latency).
- Minimum from first sample to out_valid: STABLE_CNT full scans + 1 cycle; exact lock edge per digit is set by strobe order.
- Handshake: transfer on an edge with out_valid && out_ready. A back-to-back load on that same edge is allowed if the mask is full.
- No combinational path from out_ready to out_valid/value.
- rst_n asserts asynchronously and releases synchronously to clk (external synchronizer).

## Structure

- Package seg7_pkg:
  - Glyph constants (primary and alternate).
  - SEG7_INVALID = 4'hF.
  - Segment-bit index names.
- Sub-module seg7_glyph_dec: combinational 7→4 decoder with ALT_GLYPHS parameter, instantiated once on seg_in.
- Per-digit debounce state lives in generate loops in the top module.

## Test plan

- Frame capture: NUM_DIGITS=4, STABLE_CNT=3; scan glyphs "1","2","3","4" three full scans, out_ready=1 → out_valid rises 1 cycle after the last lock, value=16'h4321, err=0.
- Debounce reset: digit 0 samples 0000110, 0000110, 1011011, 1011011, 1011011 → digit 0 locks only as 2, no earlier frame carries 1.
- Invalid glyph plus alternates: digit 2 shows 0000000 and digit 1 shows 1111101 (ALT_GLYPHS=1) → value digit 2 = F, err=4'b0100, digit 1 = 6. With ALT_GLYPHS=0, digit 1 = F.
- Backpressure: hold out_ready=0 for 20 cycles while glyphs change → value/err frozen. Raise out_ready → transfer, then the next frame carries the latest locked codes.
- Bad strobe and reset: digit_sel=4'b0011 → sel_err=1 and no state change. Assert rst_n=0 mid-handshake → all outputs 0 immediately (asynchronous); after release, the first frame needs full re-lock.
